// File: rtl/config_accumulator.sv
// Multiply-accumulate sink: sums signed 8-bit products (full) or two 4-bit lanes (halved); CONFIG_ACCUMULATOR_SATURATE_EN selects clamping sums.
// Result valid one cycle after the final beat; prod_ready_o only in ACCUM, result held in DONE until acc_ready_i.
module config_accumulator #(
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   halved_i,
  input  logic [CNT_WIDTH-1:0]   len_i,
  input  logic                   prod_valid_i,
  output logic                   prod_ready_o,
  input  logic [7:0]             prod_i,
  output logic                   acc_valid_o,
  input  logic                   acc_ready_i,
  output logic [2*ACC_WIDTH-1:0] acc_o,
  output logic                   busy_o,
  output logic                   overflow_o
);

  localparam int FW = 2 * ACC_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} stateT;

  stateT                 state, stateNext;
  logic                  halvedQ;
  logic [CNT_WIDTH-1:0]  lenQ;
  logic [CNT_WIDTH-1:0]  beatCnt;
  logic [CNT_WIDTH-1:0]  cntInc;
  logic [FW-1:0]         acc;
  logic [FW-1:0]         accNext;
  logic                  ovfQ;
  logic                  beatOvf;
  logic                  startTake;
  logic                  beatTake;

  logic [FW-1:0]         fullAdd, fullSum;
  logic [ACC_WIDTH-1:0]  hiAdd, loAdd, hiSum, loSum;
`ifdef CONFIG_ACCUMULATOR_SATURATE_EN
  logic                  fullOvf, hiOvf, loOvf;
`endif

  assign cntInc = beatCnt + CNT_WIDTH'(1);

  always_comb begin
    stateNext    = state;
    prod_ready_o = 1'b0;
    acc_valid_o  = 1'b0;
    startTake    = 1'b0;
    beatTake     = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          startTake = 1'b1;
          stateNext = (len_i != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        prod_ready_o = 1'b1;
        if (prod_valid_i) begin
          beatTake = 1'b1;
          if (cntInc == lenQ) stateNext = DONE;
        end
      end
      DONE: begin
        acc_valid_o = 1'b1;
        if (acc_ready_i) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= stateNext;
  end

  // Lanes are summed independently so no carry leaks from low into high.
  always_comb begin
    fullAdd = {{(FW-8){prod_i[7]}}, prod_i};
    hiAdd   = {{(ACC_WIDTH-4){prod_i[7]}}, prod_i[7:4]};
    loAdd   = {{(ACC_WIDTH-4){prod_i[3]}}, prod_i[3:0]};
    fullSum = acc + fullAdd;
    hiSum   = acc[FW-1:ACC_WIDTH] + hiAdd;
    loSum   = acc[ACC_WIDTH-1:0] + loAdd;
`ifdef CONFIG_ACCUMULATOR_SATURATE_EN
    fullOvf = (acc[FW-1] == fullAdd[FW-1]) && (fullSum[FW-1] != acc[FW-1]);
    hiOvf   = (acc[FW-1] == hiAdd[ACC_WIDTH-1]) && (hiSum[ACC_WIDTH-1] != acc[FW-1]);
    loOvf   = (acc[ACC_WIDTH-1] == loAdd[ACC_WIDTH-1]) &&
              (loSum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    if (fullOvf) fullSum = acc[FW-1] ? {1'b1, {(FW-1){1'b0}}} : {1'b0, {(FW-1){1'b1}}};
    if (hiOvf)   hiSum = acc[FW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    if (loOvf)   loSum = acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                          : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    beatOvf = halvedQ ? (hiOvf | loOvf) : fullOvf;
`else
    beatOvf = 1'b0;
`endif
    accNext = halvedQ ? {hiSum, loSum} : fullSum;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      halvedQ <= 1'b0;
      lenQ    <= '0;
      beatCnt <= '0;
      acc     <= '0;
      ovfQ    <= 1'b0;
    end else if (startTake) begin
      halvedQ <= halved_i;
      lenQ    <= len_i;
      beatCnt <= '0;
      acc     <= '0;
      ovfQ    <= 1'b0;
    end else if (beatTake) begin
      beatCnt <= cntInc;
      acc     <= accNext;
      ovfQ    <= ovfQ | beatOvf;
    end
  end

  assign acc_o      = acc;
  assign busy_o     = (state != IDLE);
  assign overflow_o = ovfQ;

endmodule

// File: tb/tb_config_accumulator.sv
// Directed bench for config_accumulator: default 16-bit instance plus an 8-bit instance for lane saturation/wrap.
module tb_config_accumulator;

  logic        clk;
  logic        rst;
  logic        start, halved, prodValid, accReady;
  logic [7:0]  len, prod;
  logic        prodReady, accValid, busy, ovf;
  logic [31:0] acc;

  logic        start8, halved8, prodValid8, accReady8;
  logic [7:0]  len8, prod8;
  logic        prodReady8, accValid8, busy8, ovf8;
  logic [15:0] acc8;

  int checks = 0;
  int errors = 0;

  config_accumulator #(.ACC_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .halved_i(halved), .len_i(len),
    .prod_valid_i(prodValid), .prod_ready_o(prodReady), .prod_i(prod),
    .acc_valid_o(accValid), .acc_ready_i(accReady), .acc_o(acc),
    .busy_o(busy), .overflow_o(ovf)
  );

  config_accumulator #(.ACC_WIDTH(8), .CNT_WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .halved_i(halved8), .len_i(len8),
    .prod_valid_i(prodValid8), .prod_ready_o(prodReady8), .prod_i(prod8),
    .acc_valid_o(accValid8), .acc_ready_i(accReady8), .acc_o(acc8),
    .busy_o(busy8), .overflow_o(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic startJob(input logic h, input logic [7:0] n);
    start  = 1'b1;
    halved = h;
    len    = n;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic acceptResult();
    accReady = 1'b1;
    @(negedge clk);
    accReady = 1'b0;
    checkVal("idleValid", 64'(accValid), 64'h0);
    checkVal("idleBusy", 64'(busy), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; halved = 1'b0; len = '0; prodValid = 1'b0;
    prod = '0; accReady = 1'b0;
    start8 = 1'b0; halved8 = 1'b0; len8 = '0; prodValid8 = 1'b0;
    prod8 = '0; accReady8 = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("rstAcc", 64'(acc), 64'h0);
    checkVal("rstValid", 64'(accValid), 64'h0);
    checkVal("rstReady", 64'(prodReady), 64'h0);
    checkVal("rstBusy", 64'(busy), 64'h0);
    checkVal("rstOvf", 64'(ovf), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Full mode 0x7F + 0x80 + 0x05 = 4, with a valid gap and mode/len toggled mid-job
    startJob(1'b0, 8'd3);
    checkVal("fullReady", 64'(prodReady), 64'h1);
    checkVal("fullBusy", 64'(busy), 64'h1);
    prodValid = 1'b1; prod = 8'h7F; halved = 1'b1; len = 8'd1;
    @(negedge clk);
    checkVal("fullBeat1", 64'(acc), 64'h7F);
    prodValid = 1'b0; prod = 8'h55;
    @(negedge clk);
    checkVal("gapAcc", 64'(acc), 64'h7F);
    checkVal("gapReady", 64'(prodReady), 64'h1);
    prodValid = 1'b1; prod = 8'h80;
    @(negedge clk);
    checkVal("fullBeat2Valid", 64'(accValid), 64'h0);
    checkVal("fullBeat2Acc", 64'(acc), 64'hFFFFFFFF);
    prod = 8'h05;
    @(negedge clk);
    prodValid = 1'b0;
    checkVal("fullValid", 64'(accValid), 64'h1);
    checkVal("fullAcc", 64'(acc), 64'h00000004);
    checkVal("fullDoneReady", 64'(prodReady), 64'h0);
    checkVal("fullOvf", 64'(ovf), 64'h0);
    acceptResult();

    // Halved: 0x3F,0x92 -> high 3-7=-4, low -1+2=1; then held in DONE with start pulses
    startJob(1'b1, 8'd2);
    prodValid = 1'b1; prod = 8'h3F;
    @(negedge clk);
    prod = 8'h92;
    @(negedge clk);
    prodValid = 1'b0;
    checkVal("halfAcc", 64'(acc), 64'hFFFC0001);
    checkVal("halfValid", 64'(accValid), 64'h1);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; halved = 1'b0; len = 8'd3;
      @(negedge clk);
      checkVal("holdAcc", 64'(acc), 64'hFFFC0001);
      checkVal("holdReady", 64'(prodReady), 64'h0);
      checkVal("holdValid", 64'(accValid), 64'h1);
    end
    start = 1'b0;
    acceptResult();

    // Zero-length job completes the cycle after start
    startJob(1'b0, 8'd0);
    checkVal("zeroValid", 64'(accValid), 64'h1);
    checkVal("zeroAcc", 64'(acc), 64'h0);
    checkVal("zeroReady", 64'(prodReady), 64'h0);
    acceptResult();

    // Reset mid-job beats start and beat handshakes in the same cycle
    startJob(1'b0, 8'd4);
    prodValid = 1'b1; prod = 8'h10;
    @(negedge clk);
    prod = 8'h20;
    @(negedge clk);
    checkVal("partialAcc", 64'(acc), 64'h30);
    rst = 1'b1; start = 1'b1; accReady = 1'b1;
    @(negedge clk);
    checkVal("midRstAcc", 64'(acc), 64'h0);
    checkVal("midRstReady", 64'(prodReady), 64'h0);
    checkVal("midRstValid", 64'(accValid), 64'h0);
    checkVal("midRstBusy", 64'(busy), 64'h0);
    checkVal("midRstOvf", 64'(ovf), 64'h0);
    rst = 1'b0; start = 1'b0; accReady = 1'b0; prodValid = 1'b0;
    @(negedge clk);
    startJob(1'b0, 8'd1);
    prodValid = 1'b1; prod = 8'h02;
    @(negedge clk);
    prodValid = 1'b0;
    checkVal("freshAcc", 64'(acc), 64'h00000002);
    checkVal("freshValid", 64'(accValid), 64'h1);
    acceptResult();

    // 8-bit lanes, twenty beats of +7 per lane: 140 clamps to 127 or wraps to -116
    start8 = 1'b1; halved8 = 1'b1; len8 = 8'd20;
    @(negedge clk);
    start8 = 1'b0;
    prodValid8 = 1'b1; prod8 = 8'h77;
    repeat (20) @(negedge clk);
    prodValid8 = 1'b0;
    checkVal("lane8Valid", 64'(accValid8), 64'h1);
`ifdef CONFIG_ACCUMULATOR_SATURATE_EN
    checkVal("lane8Acc", 64'(acc8), 64'h7F7F);
    checkVal("lane8Ovf", 64'(ovf8), 64'h1);
`else
    checkVal("lane8Acc", 64'(acc8), 64'h8C8C);
    checkVal("lane8Ovf", 64'(ovf8), 64'h0);
`endif
    accReady8 = 1'b1;
    @(negedge clk);
    accReady8 = 1'b0;
    checkVal("lane8Busy", 64'(busy8), 64'h0);
    start8 = 1'b1; len8 = 8'd0;
    @(negedge clk);
    start8 = 1'b0;
    checkVal("lane8OvfClear", 64'(ovf8), 64'h0);
    checkVal("lane8ZeroAcc", 64'(acc8), 64'h0);
    checkVal("lane8Ready", 64'(prodReady8), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_accumulator.md
CONFIG_ACCUMULATOR -- requirements
Module: config_accumulator

Interface
REQ-001 Parameter ACC_WIDTH, default 16, per-lane accumulator width in halved mode; full-mode accumulator width is 2*ACC_WIDTH; legal range 8..32.
REQ-002 Parameter CNT_WIDTH, default 8, width of the job length field.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  job start request; sampled only in IDLE.
REQ-006 halved_i  input  1  0: one signed 8-bit product per beat; 1: two signed 4-bit products per beat ([7:4] high lane, [3:0] low lane).
REQ-007 len_i  input  CNT_WIDTH  number of product beats in the job, unsigned.
REQ-008 prod_valid_i  input  1  product beat valid.
REQ-009 prod_ready_o  output  1  block accepts a product beat.
REQ-010 prod_i  input  8  signed product word from the configurable multiplier.
REQ-011 acc_valid_o  output  1  result valid.
REQ-012 acc_ready_i  input  1  downstream accepts result.
REQ-013 acc_o  output  2*ACC_WIDTH  full mode: one signed sum; halved mode: {high-lane sum, low-lane sum}, each ACC_WIDTH signed.
REQ-014 busy_o  output  1  high whenever state is not IDLE.
REQ-015 overflow_o  output  1  sticky per-job saturation flag (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, ACCUM, DONE.
REQ-017 IDLE: start_i=1 latches halved_i and len_i, clears accumulator and overflow_o; next state ACCUM if len_i!=0, else DONE.
REQ-018 start_i SHALL be ignored in ACCUM and DONE.
REQ-019 prod_ready_o SHALL be 1 exactly in ACCUM; a beat transfers when prod_valid_i && prod_ready_o.
REQ-020 Full mode: each beat adds prod_i sign-extended to 2*ACC_WIDTH.
REQ-021 Halved mode: high lane adds prod_i[7:4] sign-extended to ACC_WIDTH, low lane adds prod_i[3:0] sign-extended; no carry crosses lanes.
REQ-022 A beat counter SHALL count transferred beats; the transfer of beat len moves ACCUM->DONE in the same edge; prod_ready_o is 0 the next cycle.
REQ-023 Latency: acc_valid_o SHALL be 1 in the cycle after the final beat transfer (cycle after start for len_i=0).
REQ-024 DONE: acc_valid_o=1; acc_o and overflow_o SHALL stay stable until acc_ready_i=1, then next state IDLE; a new start is accepted no earlier than the following cycle.
REQ-025 prod_valid_i gaps in ACCUM SHALL stall without changing accumulator or counter.
REQ-026 latched mode and length SHALL not change during a job regardless of halved_i/len_i.

Reset
REQ-027 rst_i=1 at any edge, including mid-ACCUM or in DONE, SHALL force IDLE, acc_o=0, counter=0, overflow_o=0, prod_ready_o=0, acc_valid_o=0, busy_o=0; partial job discarded.
REQ-028 rst_i SHALL take priority over start_i and all handshakes in the same cycle.

Configuration
REQ-029 Macro CONFIG_ACCUMULATOR_SATURATE_EN defined: each sum (full, or each lane) SHALL clamp to its signed max/min on overflow and set overflow_o=1 until next start or reset.
REQ-030 Macro undefined: sums SHALL wrap modulo 2^width and overflow_o SHALL be constant 0.

Verification
REQ-031 Full, ACC_WIDTH=16, len=3, prod 0x7F,0x80,0x05 -> acc_o=0x00000004, acc_valid_o one cycle after third beat.
REQ-032 Halved, ACC_WIDTH=16, len=2, prod 0x3F,0x92 -> acc_o=0xFFFC0001 (high -4, low +1).
REQ-033 start_i with len=0 -> acc_valid_o next cycle, acc_o=0, prod_ready_o never 1.
REQ-034 DONE with acc_ready_i low 5 cycles, start_i pulsed -> acc_o stable, prod_ready_o=0, start ignored, IDLE after acc_ready_i.
REQ-035 Halved, ACC_WIDTH=8, len=20, prod 0x77 -> with macro acc_o=0x7F7F, overflow_o=1; without macro acc_o=0x8C8C, overflow_o=0.
REQ-036 rst_i asserted after 2 of 4 beats -> all outputs zero next cycle; fresh job of len=1 prod 0x02 -> acc_o=0x00000002.
